// File: rtl/tm_key_events_if.sv
// Scan input and event output bundle of the TM1638 key event block.
// sample is qualified by the one-cycle sample_valid strobe. An event transfers on any edge where evt_valid && evt_ready; evt_key/evt_press are stable while evt_valid waits.
interface tm_key_events_if;
  logic       sample_valid;
  logic [7:0] sample;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_key;
  logic       evt_press;

  modport master (
    output sample_valid, sample, evt_ready,
    input  evt_valid, evt_key, evt_press
  );

  modport slave (
    input  sample_valid, sample, evt_ready,
    output evt_valid, evt_key, evt_press
  );
endinterface

// File: rtl/tm_key_events.sv
// Debounces eight TM1638 keys and queues press/release events in a FWFT FIFO.
// Each key has one pending slot, and a fixed-priority arbiter drains these slots into the FIFO.
module tm_key_events #(
    parameter int DEBOUNCE_SCANS = 3,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    tm_key_events_if.slave                bus,
    output logic [7:0]                    keys_stable,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [3:0]  DB_LAST = 4'(DEBOUNCE_SCANS - 1);
    localparam logic [AW:0] DEPTH   = (AW + 1)'(FIFO_DEPTH);

    logic [3:0]    cnt [8];
    logic [7:0]    pend;
    logic [7:0]    pend_type;
    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic [7:0] evt_gen;
    logic [7:0] push_onehot;
    logic [2:0] push_key;
    logic       push;
    logic       pop;
    logic       lost;

    always_comb begin
        evt_gen = '0;
        for (int i = 0; i < 8; i++) begin
            evt_gen[i] = bus.sample_valid && (bus.sample[i] != keys_stable[i]) && (cnt[i] == DB_LAST);
        end
    end

    // The loop runs downward, so the lowest set pend bit wins.
    always_comb begin
        push_key = '0;
        for (int i = 7; i >= 0; i--) begin
            if (pend[i]) push_key = 3'(i);
        end
        push        = (pend != 8'h00) && (count < DEPTH);
        push_onehot = push ? (8'h01 << push_key) : 8'h00;
    end

    // A slot being pushed this cycle hands its old event to the FIFO, so refilling it loses nothing.
    assign lost = |(evt_gen & pend & ~push_onehot);

    assign pop           = bus.evt_valid & bus.evt_ready;
    assign bus.evt_valid = (count != '0);
    assign bus.evt_key   = mem[rd_ptr][3:1];
    assign bus.evt_press = mem[rd_ptr][0];
    assign occupancy     = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            keys_stable <= '0;
            pend        <= '0;
            pend_type   <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            for (int i = 0; i < 8; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (bus.sample_valid) begin
                    if (bus.sample[i] == keys_stable[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] == DB_LAST) begin
                        keys_stable[i] <= ~keys_stable[i];
                        cnt[i]         <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 4'd1;
                    end
                end
                if (evt_gen[i]) begin
                    pend[i]      <= 1'b1;
                    pend_type[i] <= bus.sample[i];
                end else if (push_onehot[i]) begin
                    pend[i] <= 1'b0;
                end
            end

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (lost)              overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= {push_key, pend_type[push_key]};
    end

endmodule

// File: tb/tb_tm_key_events.sv
// Directed bench for tm_key_events. Expected events are queued at stimulus time,
// and a negedge monitor pops and compares every accepted event.
module tb_tm_key_events;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr_overflow = 1'b0;
  logic [7:0] keys_stable;
  logic       overflow;
  logic [3:0] occupancy;
  logic [7:0] s;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q[$];

  tm_key_events_if bus();

  tm_key_events #(.DEBOUNCE_SCANS(3), .FIFO_DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .keys_stable  (keys_stable),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .occupancy    (occupancy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin : monitor
    logic [3:0] e;
    if (!rst && bus.evt_valid && bus.evt_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: got key=%0d press=%0d, required no event", bus.evt_key, bus.evt_press);
      end else begin
        e = exp_q.pop_front();
        if ({bus.evt_key, bus.evt_press} !== e) begin
          failures++;
          $display("FAIL event_order: got key=%0d press=%0d, required key=%0d press=%0d",
                   bus.evt_key, bus.evt_press, e[3:1], e[0]);
        end
      end
    end
  end

  // driver tasks: each starts and ends 1 ns after a rising edge
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [7:0] v);
    bus.sample_valid = 1'b1;
    bus.sample       = v;
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
  endtask

  task automatic strobe_n(input logic [7:0] v, input int n);
    repeat (n) strobe(v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    idle(2);
    rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      idle(1);
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  int keys_a[7] = '{0, 1, 3, 4, 5, 6, 7};

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample       = 8'h00;
    bus.evt_ready    = 1'b0;
    s                = 8'h00;
    @(posedge clk);
    #1;
    do_reset();
    check("reset_keys_stable", keys_stable, 8'h00);
    check("reset_evt_valid", bus.evt_valid, 0);
    check("reset_overflow", overflow, 0);
    check("reset_occupancy", occupancy, 0);

    // single press, latency
    bus.evt_ready = 1'b1;
    exp_q.push_back({3'd0, 1'b1});
    strobe_n(8'h01, 2);
    check("db_not_yet_stable", keys_stable, 8'h00);
    strobe(8'h01);
    check("db_stable_after_3", keys_stable, 8'h01);
    check("lat_not_early", bus.evt_valid, 0);
    idle(1);
    check("lat_valid_rise", bus.evt_valid, 1);
    check("lat_key", {bus.evt_key, bus.evt_press}, {3'd0, 1'b1});
    idle(1);
    check("single_event_only", bus.evt_valid, 0);

    // bounce resets the counter
    do_reset();
    strobe(8'h01); strobe(8'h01); strobe(8'h00); strobe(8'h01); strobe(8'h01);
    idle(4);
    check("bounce_keys_stable", keys_stable, 8'h00);
    check("bounce_no_event", bus.evt_valid, 0);
    exp_q.push_back({3'd0, 1'b1});
    strobe(8'h01);
    idle(4);
    check("bounce_then_accept", keys_stable, 8'h01);
    check("bounce_event_seen", exp_q.size(), 0);

    // two keys in one scan, ascending order
    do_reset();
    exp_q.push_back({3'd0, 1'b1});
    exp_q.push_back({3'd7, 1'b1});
    strobe_n(8'h81, 3);
    check("multi_keys_stable", keys_stable, 8'h81);
    idle(1);
    check("multi_first_key", {bus.evt_valid, bus.evt_key}, {1'b1, 3'd0});
    idle(1);
    check("multi_second_key", {bus.evt_valid, bus.evt_key}, {1'b1, 3'd7});
    idle(2);
    check("multi_all_seen", exp_q.size(), 0);

    // fill FIFO, two more events held pending
    do_reset();
    bus.evt_ready = 1'b0;
    s = 8'h00;
    for (int k = 0; k < 8; k++) begin
      s[k] = 1'b1;
      exp_q.push_back({3'(k), 1'b1});
      strobe_n(s, 3);
    end
    s[0] = 1'b0; exp_q.push_back({3'd0, 1'b0}); strobe_n(s, 3);
    s[1] = 1'b0; exp_q.push_back({3'd1, 1'b0}); strobe_n(s, 3);
    idle(3);
    check("full_occupancy", occupancy, 8);
    check("full_no_overflow", overflow, 0);
    check("full_keys_stable", keys_stable, 8'hFC);
    check("full_head", {bus.evt_valid, bus.evt_key, bus.evt_press}, {1'b1, 3'd0, 1'b1});
    bus.evt_ready = 1'b1;
    drain(40);

    // overflow on a pending key, clear, set-wins
    do_reset();
    bus.evt_ready = 1'b0;
    s = 8'h00;
    foreach (keys_a[j]) begin
      s[keys_a[j]] = 1'b1;
      exp_q.push_back({3'(keys_a[j]), 1'b1});
      strobe_n(s, 3);
    end
    s[0] = 1'b0; exp_q.push_back({3'd0, 1'b0}); strobe_n(s, 3);
    s[2] = 1'b1; strobe_n(s, 3);
    idle(2);
    check("ovf_full_occupancy", occupancy, 8);
    check("ovf_full_no_set", overflow, 0);
    s[2] = 1'b0; strobe_n(s, 3);
    idle(1);
    check("ovf_set", overflow, 1);
    clr_overflow = 1'b1;
    idle(1);
    clr_overflow = 1'b0;
    check("ovf_cleared", overflow, 0);
    s[2] = 1'b1;
    strobe_n(s, 2);
    clr_overflow = 1'b1;
    strobe(s);
    clr_overflow = 1'b0;
    check("ovf_set_wins", overflow, 1);
    check("ovf_keys_stable", keys_stable, 8'hFE);
    exp_q.push_back({3'd2, 1'b1});
    bus.evt_ready = 1'b1;
    drain(40);
    idle(3);
    check("ovf_fifo_empty", bus.evt_valid, 0);

    // reset mid-debounce with events queued
    do_reset();
    bus.evt_ready = 1'b0;
    s = 8'h00;
    for (int k = 0; k < 3; k++) begin
      s[k] = 1'b1;
      exp_q.push_back({3'(k), 1'b1});
      strobe_n(s, 3);
    end
    idle(2);
    check("rst_pre_occupancy", occupancy, 3);
    strobe_n(8'h0F, 2);
    rst = 1'b1;
    exp_q.delete();
    bus.sample_valid = 1'b1;
    bus.sample       = 8'h0F;
    idle(1);
    check("rst_flush_valid", bus.evt_valid, 0);
    check("rst_flush_keys", keys_stable, 8'h00);
    idle(1);
    rst = 1'b0;
    bus.sample_valid = 1'b0;
    bus.evt_ready = 1'b1;
    strobe(8'h0F);
    idle(6);
    check("rst_after_no_event", bus.evt_valid, 0);
    check("rst_after_keys", keys_stable, 8'h00);
    check("rst_after_occupancy", occupancy, 0);
    check("rst_after_overflow", overflow, 0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
